// File: rtl/decode_stage_pkg.sv
// Shared bus/format/opcode macros and the decode-stage package.
// Holds the FSM state encoding and the packed beat record that moves
// through the output and skid registers. No ports.
`ifndef DECODE_STAGE_DEFINES
`define DECODE_STAGE_DEFINES
`define INSTR_BUS     31:0
`define REG_BUS       31:0
`define IMMG_OP_BUS   2:0
`define IMMG_OP_I     3'd0
`define IMMG_OP_S     3'd1
`define IMMG_OP_B     3'd2
`define IMMG_OP_U     3'd3
`define IMMG_OP_J     3'd4
`define IMMG_OP_NONE  3'd7
`define OPC_LOAD      7'b0000011
`define OPC_OPIMM     7'b0010011
`define OPC_JALR      7'b1100111
`define OPC_STORE     7'b0100011
`define OPC_BRANCH    7'b1100011
`define OPC_LUI       7'b0110111
`define OPC_AUIPC     7'b0010111
`define OPC_JAL       7'b1101111
`define OPC_OP        7'b0110011
`define OPC_FENCE     7'b0001111
`define OPC_SYSTEM    7'b1110011
`endif

package decode_stage_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   typedef struct packed {
      logic [`INSTR_BUS]   instr;
      logic [`REG_BUS]     pc;
      logic [`REG_BUS]     imm;
      logic [`IMMG_OP_BUS] op;
      logic                illegal;
   } beat_t;

   localparam beat_t BEAT_RESET = '{
      instr:   32'd0,
      pc:      32'd0,
      imm:     32'd0,
      op:      `IMMG_OP_NONE,
      illegal: 1'b0
   };

endpackage

// File: rtl/imm_format_decoder.sv
// Opcode classifier: maps the 7-bit major opcode to an immediate format
// and flags opcodes the core does not implement.
// Ports: opcode_i (instr[6:0]), immg_op_o (format), illegal_o.
module imm_format_decoder (
   input  logic [6:0]          opcode_i,
   output logic [`IMMG_OP_BUS] immg_op_o,
   output logic                illegal_o
);

   // Opcode to format lookup; unknown opcodes carry no immediate.
   always_comb begin
      immg_op_o = `IMMG_OP_NONE;
      illegal_o = 1'b0;
      case (opcode_i)
         `OPC_LOAD, `OPC_OPIMM, `OPC_JALR: immg_op_o = `IMMG_OP_I;
         `OPC_STORE:                       immg_op_o = `IMMG_OP_S;
         `OPC_BRANCH:                      immg_op_o = `IMMG_OP_B;
         `OPC_LUI, `OPC_AUIPC:             immg_op_o = `IMMG_OP_U;
         `OPC_JAL:                         immg_op_o = `IMMG_OP_J;
         `OPC_OP, `OPC_FENCE, `OPC_SYSTEM: immg_op_o = `IMMG_OP_NONE;
         default: begin
            immg_op_o = `IMMG_OP_NONE;
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/immediate_generator.sv
// Immediate generator: builds the sign-extended immediate for the given
// format from instruction bits [31:7].
// Ports: instr_i (instruction bits 31:7), immg_op_i (format), imm_o.
module immediate_generator (
   input  logic [31:7]         instr_i,
   input  logic [`IMMG_OP_BUS] immg_op_i,
   output logic [`REG_BUS]     imm_o
);

   // Format-dependent bit gather with sign extension from bit 31.
   always_comb begin
      imm_o = 32'd0;
      case (immg_op_i)
         `IMMG_OP_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
         `IMMG_OP_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         `IMMG_OP_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
         `IMMG_OP_U: imm_o = {instr_i[31:12], 12'd0};
         `IMMG_OP_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
         default:    imm_o = 32'd0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode pipeline stage. Classifies the fetched instruction,
// generates its immediate and stores the decoded beat in a two-entry
// skid buffer (output register + skid register).
// Ports: clk, rst_n (async active-low); fetch side if_valid_i/if_ready_o/
// if_instr_i/if_pc_i; flush_i; execute side id_valid_o/id_ready_i/
// id_instr_o/id_pc_o/id_imm_o/id_immg_op_o/id_illegal_o.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_valid_i,
   output logic                if_ready_o,
   input  logic [`INSTR_BUS]   if_instr_i,
   input  logic [XLEN-1:0]     if_pc_i,
   input  logic                flush_i,
   output logic                id_valid_o,
   input  logic                id_ready_i,
   output logic [`INSTR_BUS]   id_instr_o,
   output logic [XLEN-1:0]     id_pc_o,
   output logic [XLEN-1:0]     id_imm_o,
   output logic [`IMMG_OP_BUS] id_immg_op_o,
   output logic                id_illegal_o
);

   logic [`IMMG_OP_BUS] w_op;
   logic                w_illegal;
   logic [`REG_BUS]     w_gen_imm;
   logic [`REG_BUS]     w_imm;
   logic                w_accept;
   logic                w_take;
   beat_t               w_beat;

   state_e r_state;
   logic   r_if_ready;
   logic   r_id_valid;
   beat_t  r_out;
   beat_t  r_skid;

   imm_format_decoder u_fmt (
      .opcode_i  (if_instr_i[6:0]),
      .immg_op_o (w_op),
      .illegal_o (w_illegal)
   );

   immediate_generator u_immg (
      .instr_i   (if_instr_i[31:7]),
      .immg_op_i (w_op),
      .imm_o     (w_gen_imm)
   );

   // Formats without an immediate force zero so the generator's default
   // never reaches the pipeline.
   assign w_imm    = (w_op == `IMMG_OP_NONE) ? 32'd0 : w_gen_imm;
   assign w_beat   = '{instr: if_instr_i, pc: if_pc_i, imm: w_imm,
                       op: w_op, illegal: w_illegal};
   assign w_accept = if_valid_i && r_if_ready;
   assign w_take   = r_id_valid && id_ready_i;

   // Skid-buffer FSM; ready and valid are registered so no
   // combinational path exists from id_ready_i to if_ready_o.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_EMPTY;
         r_if_ready <= 1'b1;
         r_id_valid <= 1'b0;
         r_out      <= BEAT_RESET;
         r_skid     <= BEAT_RESET;
      end else if (flush_i) begin
         // Data registers keep stale contents; only control is cleared.
         r_state    <= ST_EMPTY;
         r_if_ready <= 1'b1;
         r_id_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_out      <= w_beat;
                  r_id_valid <= 1'b1;
                  r_state    <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_accept && w_take) begin
                  r_out <= w_beat;
               end else if (w_accept) begin
                  r_skid     <= w_beat;
                  r_if_ready <= 1'b0;
                  r_state    <= ST_TWO;
               end else if (w_take) begin
                  r_id_valid <= 1'b0;
                  r_state    <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (w_take) begin
                  r_out      <= r_skid;
                  r_if_ready <= 1'b1;
                  r_state    <= ST_ONE;
               end
            end
            default: begin
               r_state    <= ST_EMPTY;
               r_if_ready <= 1'b1;
               r_id_valid <= 1'b0;
            end
         endcase
      end
   end

   assign if_ready_o   = r_if_ready;
   assign id_valid_o   = r_id_valid;
   assign id_instr_o   = r_out.instr;
   assign id_pc_o      = r_out.pc;
   assign id_imm_o     = r_out.imm;
   assign id_immg_op_o = r_out.op;
   assign id_illegal_o = r_out.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        if_valid_i;
   logic        if_ready_o;
   logic [31:0] if_instr_i;
   logic [31:0] if_pc_i;
   logic        flush_i;
   logic        id_valid_o;
   logic        id_ready_i;
   logic [31:0] id_instr_o;
   logic [31:0] id_pc_o;
   logic [31:0] id_imm_o;
   logic [2:0]  id_immg_op_o;
   logic        id_illegal_o;

   int n_tests;
   int n_fail;

   decode_stage #(.XLEN(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_valid_i   (if_valid_i),
      .if_ready_o   (if_ready_o),
      .if_instr_i   (if_instr_i),
      .if_pc_i      (if_pc_i),
      .flush_i      (flush_i),
      .id_valid_o   (id_valid_o),
      .id_ready_i   (id_ready_i),
      .id_instr_o   (id_instr_o),
      .id_pc_o      (id_pc_o),
      .id_imm_o     (id_imm_o),
      .id_immg_op_o (id_immg_op_o),
      .id_illegal_o (id_illegal_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; return 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat for a single cycle with execute ready, check decode.
   task automatic decode_vec(input logic [31:0] instr, input logic [31:0] pc,
                             input logic [31:0] imm, input logic [2:0] op,
                             input logic ill);
      if_valid_i = 1'b1;
      if_instr_i = instr;
      if_pc_i    = pc;
      id_ready_i = 1'b1;
      tick();
      if_valid_i = 1'b0;
      check("dec_valid", 64'(id_valid_o), 64'd1);
      check("dec_instr", 64'(id_instr_o), 64'(instr));
      check("dec_pc",    64'(id_pc_o),    64'(pc));
      check("dec_imm",   64'(id_imm_o),   64'(imm));
      check("dec_op",    64'(id_immg_op_o), 64'(op));
      check("dec_ill",   64'(id_illegal_o), 64'(ill));
      tick();
      check("dec_drain", 64'(id_valid_o), 64'd0);
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      if_valid_i = 1'b0;
      if_instr_i = 32'd0;
      if_pc_i    = 32'd0;
      flush_i    = 1'b0;
      id_ready_i = 1'b0;

      // Reset
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("rst_valid", 64'(id_valid_o), 64'd0);
      check("rst_ready", 64'(if_ready_o), 64'd1);
      check("rst_op",    64'(id_immg_op_o), 64'd7);
      check("rst_ill",   64'(id_illegal_o), 64'd0);
      check("rst_instr", 64'(id_instr_o), 64'd0);
      check("rst_pc",    64'(id_pc_o),    64'd0);
      check("rst_imm",   64'(id_imm_o),   64'd0);

      // Format decode
      decode_vec(32'hFFF00093, 32'h0000_0010, 32'hFFFFFFFF, 3'd0, 1'b0);
      decode_vec(32'h00112423, 32'h0000_0014, 32'h00000008, 3'd1, 1'b0);
      decode_vec(32'hFE000EE3, 32'h0000_0018, 32'hFFFFFFFC, 3'd2, 1'b0);
      decode_vec(32'h123450B7, 32'h0000_001C, 32'h12345000, 3'd3, 1'b0);
      decode_vec(32'h0080006F, 32'h0000_0020, 32'h00000008, 3'd4, 1'b0);
      decode_vec(32'h00000000, 32'h0000_0024, 32'h00000000, 3'd7, 1'b1);
      decode_vec(32'h002081B3, 32'h0000_0028, 32'h00000000, 3'd7, 1'b0);
      decode_vec(32'hFFFFFFFF, 32'h0000_002C, 32'h00000000, 3'd7, 1'b1);

      // Back-pressure: three beats offered with execute stalled
      id_ready_i = 1'b0;
      if_valid_i = 1'b1;
      if_instr_i = 32'hFFF00093;
      if_pc_i    = 32'h100;
      tick();
      check("bp1_pc",    64'(id_pc_o), 64'h100);
      check("bp1_ready", 64'(if_ready_o), 64'd1);
      if_pc_i = 32'h104;
      tick();
      check("bp2_ready", 64'(if_ready_o), 64'd0);
      check("bp2_pc",    64'(id_pc_o), 64'h100);
      if_pc_i = 32'h108;
      tick();
      check("bp3_ready", 64'(if_ready_o), 64'd0);
      check("bp3_valid", 64'(id_valid_o), 64'd1);
      check("bp3_pc",    64'(id_pc_o), 64'h100);
      check("bp3_imm",   64'(id_imm_o), 64'hFFFFFFFF);
      id_ready_i = 1'b1;
      tick();
      check("bp4_pc",    64'(id_pc_o), 64'h104);
      check("bp4_ready", 64'(if_ready_o), 64'd1);
      tick();
      check("bp5_pc",    64'(id_pc_o), 64'h108);
      check("bp5_valid", 64'(id_valid_o), 64'd1);
      if_valid_i = 1'b0;
      tick();
      check("bp6_valid", 64'(id_valid_o), 64'd0);

      // Throughput: 20 back-to-back beats
      id_ready_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if_valid_i = 1'b1;
         if_pc_i    = 32'h1000 + 32'(i * 4);
         tick();
         check("tp_valid", 64'(id_valid_o), 64'd1);
         check("tp_pc",    64'(id_pc_o), 64'(32'h1000 + 32'(i * 4)));
      end
      if_valid_i = 1'b0;
      tick();
      check("tp_end", 64'(id_valid_o), 64'd0);

      // Flush while TWO with a beat offered
      id_ready_i = 1'b0;
      if_valid_i = 1'b1;
      if_pc_i    = 32'h200;
      tick();
      if_pc_i = 32'h204;
      tick();
      check("fl_two", 64'(if_ready_o), 64'd0);
      flush_i = 1'b1;
      if_pc_i = 32'h208;
      tick();
      flush_i    = 1'b0;
      if_valid_i = 1'b0;
      check("fl_valid", 64'(id_valid_o), 64'd0);
      check("fl_ready", 64'(if_ready_o), 64'd1);
      id_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("fl_quiet", 64'(id_valid_o), 64'd0);
      end

      // Flush while ONE with a beat transferring in the same cycle
      id_ready_i = 1'b0;
      if_valid_i = 1'b1;
      if_pc_i    = 32'h400;
      tick();
      flush_i = 1'b1;
      if_pc_i = 32'h404;
      tick();
      flush_i    = 1'b0;
      if_valid_i = 1'b0;
      check("fl1_valid", 64'(id_valid_o), 64'd0);
      id_ready_i = 1'b1;
      tick();
      check("fl1_quiet", 64'(id_valid_o), 64'd0);
      if_valid_i = 1'b1;
      if_pc_i    = 32'h300;
      tick();
      if_valid_i = 1'b0;
      check("fl_next_pc",    64'(id_pc_o), 64'h300);
      check("fl_next_valid", 64'(id_valid_o), 64'd1);
      tick();

      // Asynchronous reset mid-stream
      if_valid_i = 1'b1;
      if_pc_i    = 32'h500;
      tick();
      check("ar_pre", 64'(id_valid_o), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid", 64'(id_valid_o), 64'd0);
      check("ar_ready", 64'(if_ready_o), 64'd1);
      check("ar_pc",    64'(id_pc_o), 64'd0);
      if_valid_i = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("ar_after", 64'(id_valid_o), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode pipeline stage between fetch and execute.
- Classifies each incoming instruction by opcode and selects the immediate format for the immediate generator, which it instantiates.
- Registers instruction, PC, decoded immediate and format into a two-entry skid buffer with valid/ready handshakes on both sides.
- Sustains one instruction per cycle; supports flush on redirect.

Parameters:
- XLEN, 32, data/PC width; must equal the `REG_BUS` width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_valid_i  in  1  fetch beat valid
- if_ready_o  out  1  stage can accept a beat
- if_instr_i  in  32  fetched instruction
- if_pc_i  in  XLEN  PC of fetched instruction
- flush_i  in  1  synchronous flush; discard all held and incoming beats
- id_valid_o  out  1  decoded beat valid
- id_ready_i  in  1  execute stage accepts beat
- id_instr_o  out  32  held instruction
- id_pc_o  out  XLEN  held PC
- id_imm_o  out  XLEN  decoded immediate
- id_immg_op_o  out  `IMMG_OP_BUS`  immediate format of held beat
- id_illegal_o  out  1  held instruction has an unsupported opcode

Behaviour:
- Single clock clk; reset rst_n asynchronous, active-low.
- Reset values:
  - state EMPTY, id_valid_o=0, if_ready_o=1.
  - id_instr_o, id_pc_o and id_imm_o are 0.
  - id_immg_op_o=`IMMG_OP_NONE`, id_illegal_o=0.
- Reset mid-transfer drops all beats.
- Handshakes:
  - Input transfer when if_valid_i && if_ready_o.
  - Output transfer when id_valid_o && id_ready_i.
- Decode is combinational on if_instr_i[6:0] and is captured at input transfer:
  - 0000011, 0010011, 1100111 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - 0110011, 0001111, 1110011 -> NONE, imm=0
  - any other opcode -> NONE, imm=0, illegal=1
- The generator's output is never used for NONE; its X default must not propagate.
- Latency: a beat accepted in cycle n is presented on id_* in cycle n+1 when the stage was EMPTY.
- FSM states: EMPTY, ONE (output register full), TWO (output and skid registers full).
- if_ready_o = (state != TWO), driven from a register with no combinational path from id_ready_i.
- Transitions:
  - EMPTY: accept -> ONE, load output register.
  - ONE:
    - accept & take -> ONE, load output register.
    - accept & !take -> TWO, load skid register.
    - !accept & take -> EMPTY.
    - else stay ONE.
  - TWO: take -> ONE, output register <= skid register; otherwise hold. No accept is possible in TWO.
- Stability: while id_valid_o && !id_ready_i, all id_* outputs hold constant.
- Ordering: strict FIFO; the skid entry is never presented before the output entry.
- Flush:
  - flush_i has highest priority; next state EMPTY.
  - A beat transferred in the flush cycle is discarded.
  - A take in the flush cycle still completes downstream.
  - Data registers need not clear; id_valid_o must be 0 in the next cycle.
- No arithmetic beyond the generator's sign extension. PC passes through unmodified.

Decomposition:
- Shared defines.sv:
  - `INSTR_BUS`, `REG_BUS`, `IMMG_OP_BUS` (3 bits).
  - `IMMG_OP_I`=0, `IMMG_OP_S`=1, `IMMG_OP_B`=2, `IMMG_OP_U`=3, `IMMG_OP_J`=4, `IMMG_OP_NONE`=7.
  - Opcode constants `OPC_LOAD`, `OPC_OPIMM`, `OPC_JALR`, `OPC_STORE`, `OPC_BRANCH`, `OPC_LUI`, `OPC_AUIPC`, `OPC_JAL`, `OPC_OP`, `OPC_FENCE`, `OPC_SYSTEM`.
  - State encoding for EMPTY/ONE/TWO.
- Sub-modules:
  - Instantiates the existing immediate_generator on the input side.
  - A small combinational opcode classifier, imm_format_decoder (instr -> immg_op, illegal), is a natural separate sub-module.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> id_valid_o=0, if_ready_o=1, id_immg_op_o=7, id_illegal_o=0.
- Format decode, id_ready_i=1, one cycle later:
  - 0xFFF00093 (addi x1,x0,-1) -> imm 0xFFFFFFFF, op I.
  - 0xFE000EE3 (beq -4) -> imm 0xFFFFFFFC, op B.
  - 0x123450B7 (lui) -> imm 0x12345000, op U.
  - 0x0080006F (jal +8) -> imm 0x00000008, op J.
- Illegal and NONE:
  - 0x00000000 -> illegal=1, imm 0, op 7.
  - 0x002081B3 (add) -> illegal=0, imm 0, op 7.
- Back-pressure: id_ready_i=0 while 3 beats offered -> 2 accepted, if_ready_o=0 after the second; id_* stable. Raise id_ready_i -> beats emerge in order, then the third is accepted.
- Throughput: continuous if_valid_i and id_ready_i=1 for 20 beats -> 20 outputs in 20 consecutive cycles after the first, PCs in order.
- Flush: in state TWO, assert flush_i for one cycle with if_valid_i=1 -> next cycle id_valid_o=0, if_ready_o=1; no flushed beat ever appears. Asynchronous reset asserted mid-stream -> id_valid_o drops immediately.
